// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its user: start/golden-table inputs,
// block-under-test drive/readback, and sweep results. err_cnt_o exists only with TT_SWEEP_ERRCNT_EN.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int ROWS = 1 << N_IN;

    logic              start_i;
    logic [ROWS-1:0]   expected_i;
    logic              y_in_i;
    logic [N_IN-1:0]   in_vec_o;
    logic              busy_o;
    logic              done_o;
    logic [ROWS-1:0]   mask_o;
    logic              match_o;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [N_IN:0]     err_cnt_o;

    modport master (
        input  start_i, expected_i, y_in_i,
        output in_vec_o, busy_o, done_o, mask_o, match_o, err_cnt_o
    );
    modport slave (
        output start_i, expected_i, y_in_i,
        input  in_vec_o, busy_o, done_o, mask_o, match_o, err_cnt_o
    );
`else
    modport master (
        input  start_i, expected_i, y_in_i,
        output in_vec_o, busy_o, done_o, mask_o, match_o
    );
    modport slave (
        output start_i, expected_i, y_in_i,
        input  in_vec_o, busy_o, done_o, mask_o, match_o
    );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input row of a combinational block, captures its output into a minterm mask
// and compares it against a golden table. Define TT_SWEEP_ERRCNT_EN to add the err_cnt_o mismatch counter.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.master  bus
);
    localparam int ROWS = 1 << N_IN;
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_ROW    = N_IN'(ROWS - 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e            state_q,  state_d;
    logic [N_IN-1:0]   in_vec_q, in_vec_d;
    logic [CW-1:0]     settle_q, settle_d;
    logic [ROWS-1:0]   exp_q,    exp_d;
    logic [ROWS-1:0]   mask_q,   mask_d;
    logic              match_q,  match_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [ROWS-1:0]   mask_smp_s;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [N_IN:0]     err_q,    err_d;
`endif

    // Mask as it will look once the current row's sample is merged in
    always_comb begin
        mask_smp_s           = mask_q;
        mask_smp_s[in_vec_q] = bus.y_in_i;
    end

    // Sweep state machine: next state and next register values
    always_comb begin
        state_d  = state_q;
        in_vec_d = in_vec_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        mask_d   = mask_q;
        match_d  = match_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d  = DRIVE;
                    in_vec_d = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    exp_d    = bus.expected_i;
                    mask_d   = '0;
`ifdef TT_SWEEP_ERRCNT_EN
                    err_d    = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            SAMPLE: begin
                mask_d = mask_smp_s;
`ifdef TT_SWEEP_ERRCNT_EN
                if (bus.y_in_i != exp_q[in_vec_q]) begin
                    err_d = err_q + (N_IN + 1)'(1);
                end else begin
                    err_d = err_q;
                end
`endif
                // Last row keeps in_vec parked on it until the sweep returns to IDLE
                if (in_vec_q == LAST_ROW) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    match_d = (mask_smp_s == exp_q);
                end else begin
                    state_d  = DRIVE;
                    in_vec_d = in_vec_q + N_IN'(1);
                    settle_d = '0;
                end
            end
            DONE: begin
                state_d  = IDLE;
                in_vec_d = '0;
            end
            default: begin
                state_d  = IDLE;
                in_vec_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            in_vec_q <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            mask_q   <= '0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            in_vec_q <= in_vec_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            mask_q   <= mask_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef TT_SWEEP_ERRCNT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.in_vec_o = in_vec_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.mask_o   = mask_q;
    assign bus.match_o  = match_q;
`ifdef TT_SWEEP_ERRCNT_EN
    assign bus.err_cnt_o = err_q;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table vectors and random tables on a SETTLE=1 instance,
// plus hand sequences for abort, start-while-busy and a SETTLE=3 instance.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tbl_a = 8'h00;
    logic [7:0] tbl_b = 8'h00;
    int total = 0;
    int bad   = 0;
    bit last_match_a = 1'b0;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(3)) ifa ();
    truth_table_sweeper_if #(.N_IN(3)) ifb ();

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    // Block under test modelled as a lookup on the driven row
    assign ifa.y_in_i = tbl_a[ifa.in_vec_o];
    assign ifb.y_in_i = tbl_b[ifb.in_vec_o];

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] expv;
        bit         poke;
        logic [7:0] mask_exp;
        bit         match_exp;
        int         err_exp;
        string      tag;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [7:0] golden_tbl(input bit kill_row6);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            bit a = i[2];
            bit b = i[1];
            bit c = i[0];
            t[i] = (a & b) | ~(a | c);
        end
        if (kill_row6) t[6] = 1'b0;
        return t;
    endfunction

    function automatic int popcount8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // One full sweep on the SETTLE=1 instance; every row lasts 2 cycles, done after 16
    task automatic sweep_a(input vec_t v);
        int done_at = -1;
        int pulses = 0;
        int bad_vec = 0;
        int bad_busy = 0;
        int row;
        tbl_a = v.tbl;
        ifa.expected_i = v.expv;
        ifa.start_i = 1'b1;
        @(negedge clk);
        ifa.start_i = 1'b0;
        chk({v.tag, ":mask_cleared"}, 32'(ifa.mask_o), 32'h0);
        chk({v.tag, ":match_held"}, 32'(ifa.match_o), 32'(last_match_a));
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (ifa.done_o === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            row = (k / 2 > 7) ? 7 : k / 2;
            if (k <= 16 && ifa.in_vec_o !== 3'(row)) bad_vec++;
            if (k < 16 && ifa.busy_o !== 1'b1) bad_busy++;
            if (k == 3) ifa.expected_i = ~v.expv;
            if (k == 5 && v.poke) ifa.start_i = 1'b1;
            if (k == 6) ifa.start_i = 1'b0;
        end
        chk({v.tag, ":done_cycle"}, 32'(done_at), 32'd16);
        chk({v.tag, ":done_pulses"}, 32'(pulses), 32'd1);
        chk({v.tag, ":row_order"}, 32'(bad_vec), 32'd0);
        chk({v.tag, ":busy_during"}, 32'(bad_busy), 32'd0);
        chk({v.tag, ":idle_after"}, {29'd0, ifa.busy_o, ifa.done_o, 1'b0} | 32'(ifa.in_vec_o), 32'h0);
        chk({v.tag, ":mask"}, 32'(ifa.mask_o), 32'(v.mask_exp));
        chk({v.tag, ":match"}, 32'(ifa.match_o), 32'(v.match_exp));
`ifdef TT_SWEEP_ERRCNT_EN
        chk({v.tag, ":err_cnt"}, 32'(ifa.err_cnt_o), 32'(v.err_exp));
`endif
        last_match_a = v.match_exp;
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        int done_seen;
        int done_at;
        int bad_vec;
        int row;

        ifa.start_i = 1'b0; ifa.expected_i = 8'h00;
        ifb.start_i = 1'b0; ifb.expected_i = 8'h00;

        vecs[0] = '{golden_tbl(1'b0), 8'hC5, 1'b0, 8'hC5, 1'b1, 0, "golden"};
        vecs[1] = '{golden_tbl(1'b1), 8'hC5, 1'b0, 8'h85, 1'b0, 1, "fault_row6"};
        vecs[2] = '{golden_tbl(1'b0), 8'hC5, 1'b1, 8'hC5, 1'b1, 0, "start_busy"};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 0, "all_zero"};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8, "all_one"};
        vecs[5] = '{8'h3C, 8'h3D, 1'b1, 8'h3C, 1'b0, 1, "off_by_one"};

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_vec", 32'(ifa.in_vec_o), 32'h0);
        chk("reset_busy", 32'(ifa.busy_o), 32'h0);
        chk("reset_done", 32'(ifa.done_o), 32'h0);
        chk("reset_mask", 32'(ifa.mask_o), 32'h0);
        chk("reset_match", 32'(ifa.match_o), 32'h0);
        chk("reset_b", {ifb.busy_o, ifb.done_o, ifb.match_o, ifb.mask_o, ifb.in_vec_o}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            sweep_a(vecs[i]);
            @(negedge clk);
        end

        // Abort mid-sweep: asynchronous reset clears outputs at once, no done follows
        tbl_a = golden_tbl(1'b0);
        ifa.expected_i = 8'hC5;
        ifa.start_i = 1'b1;
        @(negedge clk);
        ifa.start_i = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {ifa.busy_o, ifa.done_o, ifa.match_o, ifa.mask_o, ifa.in_vec_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifa.done_o === 1'b1 || ifa.busy_o === 1'b1) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        last_match_a = 1'b0;
        sweep_a(vecs[0]);
        @(negedge clk);

        // Random tables against the table-lookup model
        for (int n = 0; n < 20; n++) begin
            rv.tbl  = 8'($urandom);
            rv.expv = ($urandom_range(1, 0) == 1) ? rv.tbl : 8'($urandom);
            rv.poke = ($urandom_range(1, 0) == 1);
            rv.mask_exp  = rv.tbl;
            rv.match_exp = (rv.tbl == rv.expv);
            rv.err_exp   = popcount8(rv.tbl ^ rv.expv);
            rv.tag = $sformatf("rand%0d", n);
            sweep_a(rv);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        // SETTLE=3 instance: each row held 4 cycles, done after 32, expected changed mid-sweep
        tbl_b = golden_tbl(1'b0);
        ifb.expected_i = 8'hC5;
        ifb.start_i = 1'b1;
        @(negedge clk);
        ifb.start_i = 1'b0;
        done_at = -1;
        bad_vec = 0;
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) @(negedge clk);
            if (ifb.done_o === 1'b1 && done_at < 0) done_at = k;
            row = (k / 4 > 7) ? 7 : k / 4;
            if (k <= 32 && ifb.in_vec_o !== 3'(row)) bad_vec++;
            if (k == 10) ifb.expected_i = 8'h00;
        end
        chk("settle3_done_cycle", 32'(done_at), 32'd32);
        chk("settle3_row_hold", 32'(bad_vec), 32'd0);
        chk("settle3_mask", 32'(ifb.mask_o), 32'hC5);
        chk("settle3_match", 32'(ifb.match_o), 32'h1);
`ifdef TT_SWEEP_ERRCNT_EN
        chk("settle3_err_cnt", 32'(ifb.err_cnt_o), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
